// File: rtl/stream_demux_buffered_if.sv
// Handshake bundle for the buffered 1-to-N stream demultiplexer:
// one shared producer port plus N per-channel consumer ports.
interface stream_demux_buffered_if #(
    parameter int WIDTH = 8,
    parameter int N     = 4,
    parameter int SELW  = $clog2(N)
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     in_data;
    logic [SELW-1:0]      in_sel;
    logic [N-1:0]         out_valid;
    logic [N-1:0]         out_ready;
    logic [N*WIDTH-1:0]   out_data;
    logic [7:0]           drop_cnt;

    modport master (
        output in_valid, in_data, in_sel, out_ready,
        input  in_ready, out_valid, out_data, drop_cnt
    );

    modport slave (
        input  in_valid, in_data, in_sel, out_ready,
        output in_ready, out_valid, out_data, drop_cnt
    );
endinterface

// File: rtl/stream_demux_buffered.sv
// Registered 1-to-N stream demultiplexer: each channel owns a single-entry
// skid-free register stage; out-of-range indices are swallowed and counted.
module stream_demux_buffered #(
    parameter  int WIDTH = 8,
    parameter  int N     = 4,
    localparam int SELW  = $clog2(N)
) (
    input  logic clk,
    input  logic rst,
    stream_demux_buffered_if.slave bus
);

    logic [N-1:0]       vld_p0;
    logic [N*WIDTH-1:0] data_p0;
    logic [7:0]         drop_p0;
    logic               in_ready;
    logic               hit;
    logic               fire;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Ready for a channel is free when empty or draining this cycle; unmatched indices always accept.
    always_comb begin
        in_ready = 1'b1;
        hit      = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (bus.in_sel == SELW'(i)) begin
                in_ready = ~vld_p0[i] | bus.out_ready[i];
                hit      = 1'b1;
            end
        end
    end

    assign fire = bus.in_valid & in_ready;

    // Stage p0: per-channel holding register and drop counter
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p0  <= '0;
            data_p0 <= '0;
            drop_p0 <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (fire && (bus.in_sel == SELW'(i))) begin
                    vld_p0[i]                  <= 1'b1;
                    data_p0[i*WIDTH +: WIDTH]  <= bus.in_data;
                end else if (vld_p0[i] && bus.out_ready[i]) begin
                    vld_p0[i] <= 1'b0;
                end
            end
            if (fire && !hit)
                drop_p0 <= sat_inc(drop_p0);
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = vld_p0;
    assign bus.out_data  = data_p0;
    assign bus.drop_cnt  = drop_p0;

endmodule

// File: tb/tb_stream_demux_buffered.sv
// Bench for stream_demux_buffered: directed scenarios plus random traffic on
// an N=4 and an N=3 instance, checked against per-channel expectation queues.
module tb_stream_demux_buffered;

    logic clk;
    logic rst;

    stream_demux_buffered_if #(.WIDTH(8), .N(4)) if4();
    stream_demux_buffered_if #(.WIDTH(8), .N(3)) if3();

    stream_demux_buffered #(.WIDTH(8), .N(4)) dut4 (.clk(clk), .rst(rst), .bus(if4.slave));
    stream_demux_buffered #(.WIDTH(8), .N(3)) dut3 (.clk(clk), .rst(rst), .bus(if3.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit started = 0;

    // Expected contents of each channel: a queue holding the word still owed to the consumer.
    logic [7:0] q [2][4][$];
    bit         zero_known [2][4];
    int         drop_exp [2];

    task automatic cmp(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input int d, input int n, input logic rs,
                              input logic iv, input logic ir, input logic [1:0] sel,
                              input logic [7:0] din, input logic [3:0] ov,
                              input logic [3:0] ordy, input logic [31:0] od,
                              input logic [7:0] dc);
        logic exp_rdy;
        int   s;
        s = int'(sel);
        exp_rdy = (s >= n) ? 1'b1 : ((q[d][s].size() == 0) || ordy[s]);
        if (started) begin
            for (int i = 0; i < n; i++) begin
                cmp($sformatf("d%0d_valid%0d", d, i), int'(ov[i]), int'(q[d][i].size() != 0));
                if (q[d][i].size() != 0)
                    cmp($sformatf("d%0d_data%0d", d, i), int'(od[i*8 +: 8]), int'(q[d][i][0]));
                else if (zero_known[d][i])
                    cmp($sformatf("d%0d_zero%0d", d, i), int'(od[i*8 +: 8]), 0);
            end
            cmp($sformatf("d%0d_drop_cnt", d), int'(dc), drop_exp[d]);
            cmp($sformatf("d%0d_in_ready_sel%0d", d, s), int'(ir), int'(exp_rdy));
        end
        if (rs) begin
            for (int i = 0; i < 4; i++) begin
                q[d][i].delete();
                zero_known[d][i] = 1;
            end
            drop_exp[d] = 0;
        end else if (started) begin
            for (int i = 0; i < n; i++) begin
                if (q[d][i].size() != 0 && ordy[i]) begin
                    void'(q[d][i].pop_front());
                    zero_known[d][i] = 0;
                end
            end
            if (iv && exp_rdy) begin
                if (s < n) begin
                    q[d][s].push_back(din);
                    zero_known[d][s] = 0;
                end else if (drop_exp[d] < 255) begin
                    drop_exp[d]++;
                end
            end
        end
    endtask

    always @(negedge clk) begin
        model_step(0, 4, rst, if4.in_valid, if4.in_ready, if4.in_sel, if4.in_data,
                   if4.out_valid, if4.out_ready, if4.out_data, if4.drop_cnt);
        model_step(1, 3, rst, if3.in_valid, if3.in_ready, if3.in_sel, if3.in_data,
                   {1'b0, if3.out_valid}, {1'b0, if3.out_ready}, {8'h00, if3.out_data},
                   if3.drop_cnt);
        if (rst) started = 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send4(input logic [1:0] sel, input logic [7:0] data);
        if4.in_valid = 1'b1;
        if4.in_sel   = sel;
        if4.in_data  = data;
    endtask

    task automatic drain_all();
        if4.in_valid  = 1'b0;
        if4.out_ready = 4'hF;
        step();
        if4.out_ready = 4'h0;
    endtask

    initial begin
        rst = 1'b1;
        if4.in_valid = 1'b0; if4.in_sel = '0; if4.in_data = '0; if4.out_ready = '0;
        if3.in_valid = 1'b0; if3.in_sel = '0; if3.in_data = '0; if3.out_ready = '0;
        step(); step();
        rst = 1'b0;

        // Reset and basic route
        send4(2'd2, 8'hA5);
        step();
        send4(2'd2, 8'h99);
        step();
        send4(2'd0, 8'h5A);
        step();
        drain_all();

        // Back-to-back streaming into a continuously drained channel
        if4.out_ready = 4'b0010;
        for (int k = 1; k <= 8; k++) begin
            send4(2'd1, 8'(k));
            step();
        end
        if4.in_valid = 1'b0;
        step(); step();
        if4.out_ready = 4'h0;

        // Stall and release
        send4(2'd0, 8'h3C);
        step();
        send4(2'd0, 8'h77);
        for (int k = 0; k < 5; k++) step();
        if4.out_ready = 4'b0001;
        step();
        if4.in_valid  = 1'b0;
        if4.out_ready = 4'h0;
        step(); step();
        drain_all();

        // Independence from a stalled channel
        send4(2'd3, 8'h33);
        step();
        send4(2'd0, 8'h11);
        step();
        send4(2'd1, 8'h22);
        step();
        if4.in_valid = 1'b0;
        step();
        drain_all();

        // Out-of-range select saturates the drop counter
        if3.in_valid = 1'b1;
        if3.in_sel   = 2'd3;
        for (int k = 0; k < 300; k++) begin
            if3.in_data = 8'($urandom);
            step();
        end
        if3.in_valid = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();

        // Reset mid-operation
        send4(2'd0, 8'hC0);
        step();
        send4(2'd2, 8'hC2);
        step();
        if4.in_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        send4(2'd2, 8'hE2);
        step();
        if4.in_valid = 1'b0;
        step(); step();
        drain_all();

        // Random traffic on both instances
        for (int k = 0; k < 600; k++) begin
            if4.in_valid  = 1'($urandom_range(0, 1));
            if4.in_sel    = 2'($urandom_range(0, 3));
            if4.in_data   = 8'($urandom);
            if4.out_ready = 4'($urandom);
            if3.in_valid  = 1'($urandom_range(0, 1));
            if3.in_sel    = 2'($urandom_range(0, 3));
            if3.in_data   = 8'($urandom);
            if3.out_ready = 3'($urandom);
            if (k == 400) rst = 1'b1;
            if (k == 401) rst = 1'b0;
            step();
        end
        if4.in_valid = 1'b0;
        if3.in_valid = 1'b0;
        step(); step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/stream_demux_buffered.md
Name: stream_demux_buffered

Overview:
- Registered 1-to-N stream demultiplexer, the distributing counterpart of the team's 2:1 selector.
- Accepts one word per cycle on a valid/ready input, steered by an index, into one of N output channels.
- Each output channel has a single-entry register stage with its own valid/ready handshake.
- Sits between a shared producer and N independent consumers.

Parameters:
- WIDTH, 8, data word width in bits.
- N, 4, number of output channels; minimum 2; need not be a power of two.
- SELW, $clog2(N), width of the steering index; derived, not overridden.

Ports:
- clk  input  1  single clock, all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  producer has a word.
- in_ready  output  1  block accepts the word this cycle.
- in_data  input  WIDTH  input word.
- in_sel  input  SELW  destination channel index.
- out_valid  output  N  bit i: channel i holds a word.
- out_ready  input  N  bit i: consumer i takes the word this cycle.
- out_data  output  N*WIDTH  channel i data at bits [i*WIDTH +: WIDTH].
- drop_cnt  output  8  saturating count of words discarded for an out-of-range in_sel.

Behaviour:
- Reset (rst=1 at a clock edge):
  - All channel full flags = 0, so out_valid = 0.
  - All out_data = 0.
  - drop_cnt = 0.
  - Any buffered words are discarded. Reset mid-transfer loses them with no partial state.
- Per channel i, state is full[i] plus data register buf[i]; out_valid[i] = full[i] and out_data slice i = buf[i].
- Input handshake:
  - The input fires when in_valid && in_ready.
  - If in_sel < N: in_ready = ~full[in_sel] | out_ready[in_sel], purely combinational.
  - If in_sel >= N: in_ready = 1. The word is accepted, discarded, and drop_cnt increments, saturating at 255.
  - in_ready must not depend on in_valid.
- Channel update each cycle:
  - drain = full[i] && out_ready[i].
  - fill = input fires && in_sel == i.
  - fill (with or without drain): buf[i] <= in_data, full[i] <= 1.
  - drain only: full[i] <= 0; buf[i] holds its old value, which is not required to be cleared.
  - neither: hold.
- Latency: a word accepted at edge k appears on out_valid/out_data after edge k, so it is visible in cycle k+1.
- Throughput: one word per cycle into a channel that is drained every cycle, with no bubbles.
- Stability: while out_valid[i]=1 and out_ready[i]=0, out_data slice i and out_valid[i] stay constant.
- Independence: a stalled channel (full, not ready) back-pressures only words addressed to it. Words to other channels flow freely.
- in_sel and in_data are ignored when in_valid=0.
- out_ready[i] is ignored when full[i]=0.
- Only one channel can fill per cycle. Any number of channels may drain in the same cycle.

Test Plan:
- Reset and basic route:
  - Stimulus: rst=1 for 2 cycles, then in_valid=1, in_sel=2, in_data=0xA5, all out_ready=0.
  - Response: after reset out_valid=0000 and drop_cnt=0; after one edge out_valid=0100 and slice 2 = 0xA5; in_ready=0 for in_sel=2 on the next cycle and 1 for in_sel=0.
- Back-to-back streaming:
  - Stimulus: out_ready[1]=1 permanently; send 0x01..0x08 to channel 1 on consecutive cycles.
  - Response: in_ready stays 1 throughout; channel 1 presents 0x01..0x08 on consecutive cycles, each one cycle after acceptance.
- Stall and release:
  - Stimulus: channel 0 full with 0x3C and out_ready[0]=0 for 5 cycles while the producer offers 0x77 to channel 0.
  - Response: in_ready=0 and slice 0 stays 0x3C for 5 cycles.
  - Stimulus: raise out_ready[0].
  - Response: in_ready=1 the same cycle; slice 0 = 0x77 next cycle.
- Independence:
  - Stimulus: channel 3 full and stalled; send 0x11 to channel 0 and 0x22 to channel 1.
  - Response: both accepted without waiting; channel 3 is unchanged.
- Out-of-range select:
  - Stimulus: N=3; send 300 words with in_sel=3.
  - Response: in_ready=1 every cycle; out_valid stays 000; drop_cnt reaches 255 and holds.
  - Stimulus: rst=1.
  - Response: drop_cnt returns to 0.
- Reset mid-operation:
  - Stimulus: channels 0 and 2 full and stalled; assert rst for 1 cycle.
  - Response: out_valid=0000 and out_data all zero after that edge; a new word to channel 2 then appears normally one cycle after acceptance.
